// File: rtl/seq_array_mult_if.sv
// Handshake bundle for seq_array_mult: operand channel (in_valid/in_ready,
// m, q, optional tc) and product channel (out_valid/out_ready, p), plus busy.
// master: the producer/consumer side driving operands and out_ready.
// slave : the multiplier itself.
// Optional tc line is present only when MULT_SIGNED_EN is defined.
interface seq_array_mult_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     m;
  logic [WIDTH-1:0]     q;
`ifdef MULT_SIGNED_EN
  logic                 tc;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;
  logic                 busy;

  modport master (
`ifdef MULT_SIGNED_EN
    output tc,
`endif
    output in_valid, m, q, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
`ifdef MULT_SIGNED_EN
    input  tc,
`endif
    input  in_valid, m, q, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/seq_array_mult.sv
// Iterative shift-add multiplier: one WIDTH x WIDTH product per transaction,
// WIDTH step cycles, one shared WIDTH-bit adder.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - seq_array_mult_if.slave (in_valid/in_ready, m, q, [tc],
//          out_valid/out_ready, p, busy)
// Macro MULT_SIGNED_EN: adds tc; operands become magnitudes on accept and the
// product is negated on DONE entry when the operand signs differ.
module seq_array_mult #(
  parameter int unsigned WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  seq_array_mult_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mreg_q, mreg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
`ifdef MULT_SIGNED_EN
  logic             neg_q, neg_d;
`endif

  logic [WIDTH-1:0] m_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   step_hi;
  logic [PW-1:0]    acc_step;
  logic [PW-1:0]    result;

  // Operand conditioning: magnitudes in signed mode, pass-through otherwise.
  always_comb begin
    m_mag = bus.m;
    q_mag = bus.q;
`ifdef MULT_SIGNED_EN
    if (bus.tc && bus.m[WIDTH-1]) m_mag = ~bus.m + WIDTH'(1);
    if (bus.tc && bus.q[WIDTH-1]) q_mag = ~bus.q + WIDTH'(1);
`endif
  end

  // One shift-add step: conditional add into the upper half, then shift right
  // with the adder carry entering at the MSB.
  always_comb begin
    add_sum  = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, mreg_q};
    step_hi  = acc_q[0] ? add_sum : {1'b0, acc_q[PW-1:WIDTH]};
    acc_step = {step_hi, acc_q[WIDTH-1:1]};
`ifdef MULT_SIGNED_EN
    result   = neg_q ? (~acc_step + PW'(1)) : acc_step;
`else
    result   = acc_step;
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    mreg_d  = mreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
`ifdef MULT_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mreg_d  = m_mag;
          acc_d   = {WIDTH'(0), q_mag};
          cnt_d   = '0;
          state_d = RUN;
`ifdef MULT_SIGNED_EN
          neg_d   = bus.tc & (bus.m[WIDTH-1] ^ bus.q[WIDTH-1]);
`endif
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          p_d     = result;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Status flags are registered copies of the next-state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN) || (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mreg_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mreg_q      <= mreg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef MULT_SIGNED_EN
      neg_q       <= neg_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.p         = p_q;

endmodule

// File: tb/tb_seq_array_mult.sv
// Directed bench for seq_array_mult: a WIDTH=4 instance (sweep, backpressure,
// back-to-back, reset mid-run, signed cases when MULT_SIGNED_EN is defined)
// and a WIDTH=8 instance for the wide build.
module tb_seq_array_mult;

  logic clk;
  logic rst;
  int   total;
  int   bad;
`ifdef MULT_SIGNED_EN
  logic tc_mode;
`endif

  seq_array_mult_if #(.WIDTH(4)) bus4 ();
  seq_array_mult_if #(.WIDTH(8)) bus8 ();

  seq_array_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  seq_array_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction on the 4-bit instance with out_ready high.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                      input string tag, input bit full);
    int n;
    bus4.m = a;
    bus4.q = b;
    bus4.in_valid = 1'b1;
    bus4.out_ready = 1'b1;
`ifdef MULT_SIGNED_EN
    bus4.tc = tc_mode;
`endif
    if (full) check({tag, "_in_ready"}, 32'(bus4.in_ready), 32'd1);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    bus4.m = 4'($urandom);
    bus4.q = 4'($urandom);
    if (full) begin
      check({tag, "_busy"}, 32'(bus4.busy), 32'd1);
      check({tag, "_in_ready_run"}, 32'(bus4.in_ready), 32'd0);
    end
    n = 0;
    while (bus4.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_p"}, 32'(bus4.p), 32'(exp));
    @(posedge clk); #1;
    if (full) check({tag, "_back_idle"}, 32'(bus4.in_ready), 32'd1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                      input string tag);
    int n;
    bus8.m = a;
    bus8.q = b;
    bus8.in_valid = 1'b1;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    n = 0;
    while (bus8.out_valid !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_p"}, 32'(bus8.p), 32'(exp));
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'(bus8.in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int k;
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.m = '0; bus4.q = '0; bus4.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.m = '0; bus8.q = '0; bus8.out_ready = 1'b1;
`ifdef MULT_SIGNED_EN
    tc_mode = 1'b0;
    bus4.tc = 1'b0;
    bus8.tc = 1'b0;
`endif

    // Reset values
    #3;
    check("rst_in_ready", 32'(bus4.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_busy", 32'(bus4.busy), 32'd0);
    check("rst_p", 32'(bus4.p), 32'd0);
    check("rst_p8", 32'(bus8.p), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Corner product with full handshake checks
    run4(4'd15, 4'd15, 8'd225, "max", 1'b1);

    // Exhaustive 4x4 sweep against the arithmetic product
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run4(4'(a), 4'(b), 8'(a * b), $sformatf("sweep_%0d_%0d", a, b), 1'b0);
      end
    end

    // Back-to-back with in_valid held high
    bus4.out_ready = 1'b1;
    bus4.m = 4'd3; bus4.q = 4'd5; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.m = 4'd0; bus4.q = 4'd12;
    k = 0;
    while (bus4.in_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (k == 4) begin
        check("b2b_first_valid", 32'(bus4.out_valid), 32'd1);
        check("b2b_first_p", 32'(bus4.p), 32'd15);
      end
    end
    check("b2b_period", 32'(k + 1), 32'd6);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    check("b2b_second_accept", 32'(bus4.busy), 32'd1);
    n = 0;
    while (bus4.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_second_latency", 32'(n), 32'd4);
    check("b2b_second_p", 32'(bus4.p), 32'd0);
    @(posedge clk); #1;

    // Backpressure: result held, new operands ignored
    bus4.m = 4'd7; bus4.q = 4'd9; bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    n = 0;
    while (bus4.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_latency", 32'(n), 32'd4);
    check("bp_p", 32'(bus4.p), 32'd63);
    for (int i = 0; i < 3; i++) begin
      bus4.in_valid = 1'b1; bus4.m = 4'd2; bus4.q = 4'd3;
      @(posedge clk); #1;
      check($sformatf("bp_hold_p_%0d", i), 32'(bus4.p), 32'd63);
      check($sformatf("bp_hold_valid_%0d", i), 32'(bus4.out_valid), 32'd1);
      check($sformatf("bp_hold_in_ready_%0d", i), 32'(bus4.in_ready), 32'd0);
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", 32'(bus4.in_ready), 32'd1);
    check("bp_release_valid", 32'(bus4.out_valid), 32'd0);
    check("bp_release_busy", 32'(bus4.busy), 32'd0);
    check("bp_release_p", 32'(bus4.p), 32'd63);

    // Reset during RUN
    bus4.m = 4'd13; bus4.q = 4'd11; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", 32'(bus4.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(bus4.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("mid_rst_busy", 32'(bus4.busy), 32'd0);
    check("mid_rst_p", 32'(bus4.p), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_no_valid", 32'(bus4.out_valid), 32'd0);
    run4(4'd2, 4'd2, 8'd4, "post_rst", 1'b1);

`ifdef MULT_SIGNED_EN
    tc_mode = 1'b1;
    run4(4'h8, 4'h8, 8'h40, "s_m8_m8", 1'b1);
    run4(4'hD, 4'h5, 8'hF1, "s_m3_5", 1'b1);
    run4(4'h7, 4'hF, 8'hF9, "s_7_m1", 1'b1);
    tc_mode = 1'b0;
    run4(4'hF, 4'hF, 8'hE1, "s_tc0", 1'b1);
`endif

    // Wide instance
    run8(8'd255, 8'd255, 16'hFE01, "w8_max");
    run8(8'd200, 8'd3, 16'd600, "w8_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
